// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface mc_ctrl_if #(
  parameter int ST_W = 5
);
  logic [5:0]      OPcode;
  logic [5:0]      Fun;
  logic            zero;
  logic            MIO_ready;
  logic            PCWrite;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegDst;
  logic            MemtoReg;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSource;
  logic [2:0]      ALU_Control;
  logic [ST_W-1:0] state_out;

  modport master (
    input  OPcode, Fun, zero, MIO_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Control, state_out
  );

  modport slave (
    output OPcode, Fun, zero, MIO_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_Control, state_out
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control FSM; Moore outputs are registered from the next-state decode.
// Define MIO_WAIT_EN to stall IF/MEM_RD/MEM_WR until the memory reports MIO_ready.
module mc_ctrl_unit #(
  parameter int ST_W = 5
) (
  input logic      clk,
  input logic      rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    S_IF     = 0,
    S_ID     = 1,
    S_EX_MEM = 2,
    S_MEM_RD = 3,
    S_WB_LW  = 4,
    S_MEM_WR = 5,
    S_EX_R   = 6,
    S_WB_R   = 7,
    S_EX_BR  = 8,
    S_EX_J   = 9,
    S_EX_I   = 10,
    S_WB_I   = 11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_ctl;
    logic       pc_write;
  } ctrl_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  ctrl_t  ctrl_q;
  logic   br_ne;
  logic   mio_ok;
  logic   pc_write;

`ifdef MIO_WAIT_EN
  assign mio_ok = bus.MIO_ready;
`else
  logic unused_mio;
  assign unused_mio = bus.MIO_ready;
  assign mio_ok     = 1'b1;
`endif

  // Returns {fun_known, alu_code}; unknown functs fall back to ADD.
  function automatic logic [3:0] fun_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, ALU_ADD};
      6'b100010: return {1'b1, ALU_SUB};
      6'b100100: return {1'b1, ALU_AND};
      6'b100101: return {1'b1, ALU_OR};
      6'b101010: return {1'b1, ALU_SLT};
      6'b100111: return {1'b1, ALU_NOR};
      6'b100110: return {1'b1, ALU_XOR};
      6'b000010: return {1'b1, ALU_SRL};
      default:   return {1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      6'b001100: return ALU_AND;
      6'b001101: return ALU_OR;
      6'b001010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic rdy);
    case (s)
      S_IF:     return rdy ? S_ID : S_IF;
      S_ID: begin
        case (op)
          6'b100011, 6'b101011:                       return S_EX_MEM;
          6'b000000:                                  return S_EX_R;
          6'b000100, 6'b000101:                       return S_EX_BR;
          6'b000010:                                  return S_EX_J;
          6'b001000, 6'b001100, 6'b001101, 6'b001010: return S_EX_I;
          default:                                    return S_IF;
        endcase
      end
      S_EX_MEM: return (op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: return rdy ? S_WB_LW : S_MEM_RD;
      S_MEM_WR: return rdy ? S_IF : S_MEM_WR;
      S_EX_R:   return S_WB_R;
      S_EX_I:   return S_WB_I;
      default:  return S_IF;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [5:0] op,
                                   input logic [5:0] fn);
    ctrl_t      c;
    logic [3:0] fa;
    c  = '0;
    fa = fun_alu(fn);
    case (s)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_ctl   = ALU_ADD;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_b = 2'b11;
        c.alu_ctl   = ALU_ADD;
      end
      S_EX_MEM: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctl   = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_WB_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EX_R: begin
        c.alu_src_a = 1'b1;
        c.alu_ctl   = fa[2:0];
      end
      S_WB_R: begin
        c.reg_write = fa[3];
        c.reg_dst   = 1'b1;
      end
      S_EX_BR: begin
        c.alu_src_a = 1'b1;
        c.alu_ctl   = ALU_SUB;
        c.pc_source = 2'b01;
      end
      S_EX_J: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_EX_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_ctl   = imm_alu(op);
      end
      S_WB_I:  c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered alongside the state so they reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IF;
      ctrl_q <= decode(S_IF, bus.OPcode, bus.Fun);
      br_ne  <= 1'b0;
    end else begin
      state  <= next_state(state, bus.OPcode, mio_ok);
      ctrl_q <= decode(next_state(state, bus.OPcode, mio_ok), bus.OPcode, bus.Fun);
      if (next_state(state, bus.OPcode, mio_ok) == S_EX_BR)
        br_ne <= bus.OPcode[0];
    end
  end

  // Branch outcome and memory handshake gate PCWrite within the current cycle.
  always_comb begin
    pc_write = ctrl_q.pc_write;
    if (state == S_EX_BR)
      pc_write = br_ne ? ~bus.zero : bus.zero;
`ifdef MIO_WAIT_EN
    if (state == S_IF)
      pc_write = bus.MIO_ready;
`endif
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.IRWrite     = ctrl_q.ir_write;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.ALU_Control = ctrl_q.alu_ctl;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Randomized bench for mc_ctrl_unit against an instruction-level reference model.
module tb_mc_ctrl_unit;
  localparam int ST_W = 5;
`ifdef MIO_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [5:0] FUNS [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h26, 6'h02};
  localparam logic [2:0] FALU [8] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7, 3'd4, 3'd3, 3'd5};
  localparam logic [5:0] OPS [10] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h02,
                                       6'h08, 6'h0c, 6'h0d, 6'h0a};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  int   trace[$];
  int   tidx;
  int   m_st;
  bit   done;
  logic [5:0] cur_op;
  logic [5:0] cur_fn;

  mc_ctrl_if #(.ST_W(ST_W)) bus ();
  mc_ctrl_unit #(.ST_W(ST_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (op=%h fn=%h t=%0t)", tag, got, exp,
               cur_op, cur_fn, $time);
    end
  endtask

  function automatic void build_trace(input logic [5:0] op);
    case (op)
      6'h23:                      trace = '{0, 1, 2, 3, 4};
      6'h2b:                      trace = '{0, 1, 2, 5};
      6'h00:                      trace = '{0, 1, 6, 7};
      6'h04, 6'h05:               trace = '{0, 1, 8};
      6'h02:                      trace = '{0, 1, 9};
      6'h08, 6'h0c, 6'h0d, 6'h0a: trace = '{0, 1, 10, 11};
      default:                    trace = '{0, 1};
    endcase
  endfunction

  // {known, alu} from the funct table; unknown functs compute ADD and never write back.
  function automatic logic [3:0] r_type(input logic [5:0] fn);
    for (int i = 0; i < 8; i++)
      if (FUNS[i] == fn) return {1'b1, FALU[i]};
    return {1'b0, 3'd2};
  endfunction

  function automatic logic [2:0] i_type(input logic [5:0] op);
    if (op == 6'h0c) return 3'd0;
    if (op == 6'h0d) return 3'd1;
    if (op == 6'h0a) return 3'd7;
    return 3'd2;
  endfunction

  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALU}
  function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic [5:0] fn);
    logic       iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] alu = 0;
    logic [3:0] rt;
    rt = r_type(fn);
    case (st)
      0:  begin mr = 1; irw = 1; sb = 2'b01; alu = 3'd2; end
      1:  begin sb = 2'b11; alu = 3'd2; end
      2:  begin sa = 1; sb = 2'b10; alu = 3'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; alu = rt[2:0]; end
      7:  begin rw = rt[3]; rd = 1; end
      8:  begin sa = 1; alu = 3'd6; ps = 2'b01; end
      9:  ps = 2'b10;
      10: begin sa = 1; sb = 2'b10; alu = i_type(op); end
      11: rw = 1;
      default: ;
    endcase
    return {iord, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu};
  endfunction

  task automatic cycle(input bit r, input bit z, input bit rdy);
    logic [14:0] got;
    logic        exp_pcw;
    rst           = r;
    bus.zero      = z;
    bus.MIO_ready = rdy;
    @(negedge clk);
    got = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
           bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALU_Control};
    case (m_st)
      0:       exp_pcw = WAIT_EN ? rdy : 1'b1;
      8:       exp_pcw = (cur_op == 6'h05) ? ~z : z;
      9:       exp_pcw = 1'b1;
      default: exp_pcw = 1'b0;
    endcase
    check_eq($sformatf("state_s%0d", m_st), 32'(bus.state_out), 32'(m_st));
    check_eq($sformatf("ctrl_s%0d", m_st), 32'(got), 32'(exp_ctrl(m_st, cur_op, cur_fn)));
    check_eq($sformatf("pcwrite_s%0d", m_st), 32'(bus.PCWrite), 32'(exp_pcw));
    if (r) begin
      m_st = 0;
      done = 1;
    end else if (!(WAIT_EN && (m_st == 0 || m_st == 3 || m_st == 5) && !rdy)) begin
      tidx++;
      if (tidx >= trace.size()) begin
        m_st = 0;
        done = 1;
      end else begin
        m_st = trace[tidx];
      end
    end
    @(posedge clk);
    #1;
  endtask

  // zmode: 0/1 fixed zero flag, 2 random. rst_at: -1 never, -2 random, else trace index.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int rst_at, input int hold);
    int n = 0;
    bit z, rdy, r;
    cur_op     = op;
    cur_fn     = fn;
    bus.OPcode = op;
    bus.Fun    = fn;
    build_trace(op);
    tidx = 0;
    m_st = 0;
    done = 0;
    while (!done && n < 64) begin
      z   = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      rdy = (n < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
      r   = (rst_at >= 0) ? (tidx == rst_at) : (rst_at == -2 && $urandom_range(0, 39) == 0);
      cycle(r, z, rdy);
      n++;
    end
    check_eq("instr_done", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    bus.OPcode    = 6'h00;
    bus.Fun       = 6'h20;
    bus.zero      = 1'b0;
    bus.MIO_ready = 1'b1;
    cur_op = 6'h00;
    cur_fn = 6'h20;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_state", 32'(bus.state_out), 32'd0);
    check_eq("reset_memwrite", 32'(bus.MemWrite), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(6'h23, 6'h20, 0, -1, 0);
    run_instr(6'h00, 6'h22, 0, -1, 0);
    run_instr(6'h04, 6'h00, 1, -1, 0);
    run_instr(6'h04, 6'h00, 0, -1, 0);
    run_instr(6'h05, 6'h00, 1, -1, 0);
    run_instr(6'h05, 6'h00, 0, -1, 0);
    run_instr(6'h3f, 6'h00, 0, -1, 0);
    run_instr(6'h2b, 6'h00, 0, 3, 0);
    run_instr(6'h02, 6'h00, 0, -1, 3);
    run_instr(6'h00, 6'h3f, 0, -1, 0);
    run_instr(6'h0d, 6'h00, 0, -1, 0);

    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 4) != 0) ? OPS[$urandom_range(0, 9)] : 6'($urandom);
      fn = ($urandom_range(0, 3) != 0) ? FUNS[$urandom_range(0, 7)] : 6'($urandom);
      run_instr(op, fn, 2, -2, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
